// File: rtl/ps2_key_flags.sv
// ---------------------------------------------------------------------------
// ps2_key_flags
//   Receives PS/2 scan-code-set-2 frames from a keyboard and keeps a bitmap of
//   the keys the overlay/aim mixer cares about (held = 1).
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   ps2_clk       raw PS/2 clock pin (asynchronous)
//   ps2_data      raw PS/2 data pin (asynchronous)
//   keyboard_data held-key flags: 0 W, 1 A, 2 S, 3 D, 4 L, 5 F1, 6 F2, 7 F3
//   scan_code     last correctly received byte
//   key_valid     one-cycle pulse when scan_code updates
//   frame_error   one-cycle pulse on parity, stop-bit or timeout error
//   dbg_state     receiver FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
// Handshake: key_valid / frame_error are single-cycle strobes with no ready
// back-pressure; the consumer must sample them in the cycle they are high.
// scan_code and keyboard_data hold their value between strobes.
// ---------------------------------------------------------------------------
module ps2_key_flags #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard_data,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic       frame_error,
  output logic [1:0] dbg_state
);

  // Timeout length in system clock cycles, computed in 64 bits to avoid
  // overflow of TIMEOUT_US * CLK_FREQ.
  localparam logic [63:0]      TO_CYC_L = (64'(TIMEOUT_US) * 64'(CLK_FREQ)) / 64'd1_000_000;
  localparam int               TO_W     = $clog2(TO_CYC_L + 64'd1);
  localparam logic [TO_W-1:0]  TO_CYC   = TO_W'(TO_CYC_L);
  localparam int               FW       = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]    FL_LAST  = FW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronisers (idle bus level is high)
  logic r_clk_s1, r_clk_s2, r_data_s1, r_data_s2;

  // Clock glitch filter
  logic [FW-1:0] r_filt_cnt;
  logic          r_filt, r_filt_d;
  logic          w_fall;

  // Receiver
  state_t          r_state, w_next;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_parity;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;
  logic            w_start, w_shift, w_par_cap, w_stop_fall;
  logic            w_frame_ok, w_frame_bad;

  // Decoder
  logic       r_brk, r_ext;
  logic       w_map_hit;
  logic [2:0] w_map_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      r_clk_s1  <= ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_data_s1 <= ps2_data;
      r_data_s2 <= r_data_s1;
    end
  end

  // The filtered clock flips only once FILTER_LEN consecutive samples have
  // disagreed with it; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt_cnt <= '0;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FL_LAST) begin
        r_filt     <= ~r_filt;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt;

  // Cycles since the last falling edge; only counts while a frame is open.
  always_ff @(posedge clk) begin
    if (reset || (r_state == S_IDLE) || w_fall) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_CYC) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_CYC);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        // A fall with data high is a bad start; ignore it silently.
        if (w_fall && !r_data_s2) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_timeout)                        w_next = S_IDLE;
        else if (w_fall && r_bit_cnt == 3'd7) w_next = S_PARITY;
      end
      S_PARITY: begin
        if (w_timeout)   w_next = S_IDLE;
        else if (w_fall) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_timeout || w_fall) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs (datapath strobes)
  always_comb begin
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_par_cap   = 1'b0;
    w_stop_fall = 1'b0;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      S_IDLE:   w_start     = w_fall && !r_data_s2;
      S_DATA:   w_shift     = w_fall;
      S_PARITY: w_par_cap   = w_fall;
      S_STOP:   w_stop_fall = w_fall;
      default:  ;
    endcase
    // Odd parity over data + parity bit, and stop bit must be high.
    w_frame_ok  = w_stop_fall && (^{r_shift, r_parity}) && r_data_s2;
    w_frame_bad = w_stop_fall && !w_frame_ok;
  end

  assign dbg_state = r_state;

  // Shift register, LSB arrives first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_timeout) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_start) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end
      if (w_shift) begin
        r_shift   <= {r_data_s2, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_cap) r_parity <= r_data_s2;
    end
  end

  always_comb begin
    w_map_hit = 1'b1;
    w_map_idx = 3'd0;
    case (r_shift)
      8'h1D:   w_map_idx = 3'd0;
      8'h1C:   w_map_idx = 3'd1;
      8'h1B:   w_map_idx = 3'd2;
      8'h23:   w_map_idx = 3'd3;
      8'h4B:   w_map_idx = 3'd4;
      8'h05:   w_map_idx = 3'd5;
      8'h06:   w_map_idx = 3'd6;
      8'h04:   w_map_idx = 3'd7;
      default: w_map_hit = 1'b0;
    endcase
  end

  // Decoder: the completed byte in r_shift is acted on in the stop-fall
  // cycle, so every output lands exactly one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      keyboard_data <= '0;
      scan_code     <= '0;
      key_valid     <= 1'b0;
      frame_error   <= 1'b0;
      r_brk         <= 1'b0;
      r_ext         <= 1'b0;
    end else begin
      key_valid   <= w_frame_ok;
      frame_error <= w_frame_bad | w_timeout;
      if (w_frame_bad || w_timeout) begin
        // A broken frame may have been part of a prefix sequence; drop it.
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (w_frame_ok) begin
        scan_code <= r_shift;
        if (r_shift == 8'hF0) begin
          r_brk <= 1'b1;
        end else if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_ext) begin
          // Extended keys are not mapped; just consume the prefixes.
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end else begin
          if (w_map_hit) keyboard_data[w_map_idx] <= ~r_brk;
          r_brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_flags.sv
module tb_ps2_key_flags;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT_US = 200;   // 200 system cycles at 1 MHz

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] keyboard_data, scan_code;
  logic key_valid, frame_error;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_key_flags #(
    .CLK_FREQ(CLK_FREQ), .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboard_data(keyboard_data), .scan_code(scan_code),
    .key_valid(key_valid), .frame_error(frame_error), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  // Entry: {check_latency, is_valid_byte, scan_code, keyboard_data}
  logic [17:0] exp_q[$];
  logic [7:0] md_kd = '0, md_scan = '0;
  bit md_brk = 0, md_ext = 0;
  int last_fall = 0;
  logic [7:0] key_codes [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h4B, 8'h05, 8'h06, 8'h04};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Apply the decoding rules to one received byte and queue the outcome.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      md_brk = 0;
      md_ext = 0;
      exp_q.push_back({1'b1, 1'b0, md_scan, md_kd});
      return;
    end
    md_scan = b;
    if (b == 8'hF0) md_brk = 1;
    else if (b == 8'hE0) md_ext = 1;
    else if (md_ext) begin
      md_ext = 0;
      md_brk = 0;
    end else begin
      for (int k = 0; k < 8; k++)
        if (key_codes[k] == b) md_kd[k] = !md_brk;
      md_brk = 0;
    end
    exp_q.push_back({1'b1, 1'b1, md_scan, md_kd});
  endtask

  // ---------------- driver tasks ----------------
  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 ps2_data = b;
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_bit);
    logic p;
    p = ~(^b) ^ par_flip;
    model_frame(b, !par_flip && stop_bit);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(stop_bit);
    ps2_data = 1'b1;
  endtask

  // Wait (bounded) until every expected event has been observed.
  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected events never seen (required 0)", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic [7:0] c_kd = '0, c_scan = '0;

  always @(negedge clk) begin
    logic [17:0] e;
    int lat;
    if (reset) begin
      c_kd   = '0;
      c_scan = '0;
    end else if (key_valid || frame_error) begin
      n_tests++;
      if (key_valid && frame_error) begin
        n_fail++;
        $display("FAIL both_strobes: key_valid and frame_error high together at cycle %0d", cyc);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: key_valid=%0b frame_error=%0b, required none, cycle %0d",
                 key_valid, frame_error, cyc);
      end else begin
        e = exp_q.pop_front();
        if (key_valid !== e[16]) begin
          n_fail++;
          $display("FAIL event_kind: key_valid=%0b required %0b at cycle %0d", key_valid, e[16], cyc);
        end
        chk("ev_scan_code", scan_code, e[15:8]);
        chk("ev_keyboard_data", keyboard_data, e[7:0]);
        if (e[17]) begin
          lat = cyc - last_fall;
          n_tests++;
          if (lat < FILTER_LEN + 1 || lat > FILTER_LEN + 5) begin
            n_fail++;
            $display("FAIL event_latency: %0d cycles after stop fall, required %0d..%0d",
                     lat, FILTER_LEN + 1, FILTER_LEN + 5);
          end
        end
        c_kd   = e[7:0];
        c_scan = e[15:8];
      end
    end else begin
      chk("hold_keyboard_data", keyboard_data, c_kd);
      chk("hold_scan_code", scan_code, c_scan);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int sel;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_kd", keyboard_data, 8'h00);
    chk("reset_scan", scan_code, 8'h00);
    chk("reset_kv", {7'd0, key_valid}, 8'h00);
    chk("reset_fe", {7'd0, frame_error}, 8'h00);
    chk("reset_state", {6'd0, dbg_state}, 8'h00);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single make code
    send_frame(8'h1D, 0, 1); drain("d_1d", 40);
    chk("kd_w_make", keyboard_data, 8'h01);
    chk("scan_1d", scan_code, 8'h1D);

    // Two keys then release W
    send_frame(8'h23, 0, 1); drain("d_23", 40);
    chk("kd_wd", keyboard_data, 8'h09);
    send_frame(8'hF0, 0, 1); drain("d_f0", 40);
    chk("scan_f0", scan_code, 8'hF0);
    chk("kd_f0_nochange", keyboard_data, 8'h09);
    send_frame(8'h1D, 0, 1); drain("d_brk1d", 40);
    chk("kd_w_break", keyboard_data, 8'h08);
    chk("scan_end_1d", scan_code, 8'h1D);
    send_frame(8'hF0, 0, 1); send_frame(8'h23, 0, 1); drain("d_brk23", 40);
    chk("kd_all_up", keyboard_data, 8'h00);

    // Parity error, then good L key
    send_frame(8'h4B, 1, 0); drain("d_bad_par", 40);
    chk("kd_after_par_err", keyboard_data, 8'h00);
    send_frame(8'h4B, 0, 1); drain("d_4b", 40);
    chk("kd_l", keyboard_data, 8'h10);
    // Stop-bit error must not disturb held keys
    send_frame(8'h1C, 0, 0); drain("d_bad_stop", 40);
    chk("kd_after_stop_err", keyboard_data, 8'h10);

    // Extended sequence ignored, then F1
    send_frame(8'hE0, 0, 1); send_frame(8'h1D, 0, 1); drain("d_ext", 40);
    chk("kd_ext_ignored", keyboard_data, 8'h10);
    send_frame(8'h05, 0, 1); drain("d_05", 40);
    chk("kd_f1", keyboard_data, 8'h30);
    // Typematic repeat and break of a key that is not held
    send_frame(8'h05, 0, 1); send_frame(8'hF0, 0, 1); send_frame(8'h1B, 0, 1);
    drain("d_repeat", 40);
    chk("kd_repeat", keyboard_data, 8'h30);

    // Timeout: start + 3 data bits, then clock stops
    model_frame(8'h00, 0);
    exp_q[exp_q.size()-1][17] = 1'b0;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (150 - 32) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_early: error seen ~150 cycles after last fall, required > 200");
    end
    drain("d_timeout", 160);
    chk("state_idle_after_to", {6'd0, dbg_state}, 8'h00);
    chk("kd_after_timeout", keyboard_data, 8'h30);
    send_frame(8'h06, 0, 1); drain("d_06", 40);
    chk("kd_f2", keyboard_data, 8'h70);

    // Glitches shorter than the filter, with data low as if a start bit
    for (int g = 0; g < 5; g++) begin
      @(posedge clk); #1 ps2_data = 1'b0; ps2_clk = 1'b0;
      repeat (FILTER_LEN - 1) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (15) @(posedge clk);
    end
    #1 ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("state_after_glitch", {6'd0, dbg_state}, 8'h00);
    // Bad start bit: full-width fall with data high
    ps2_bit(1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("state_after_bad_start", {6'd0, dbg_state}, 8'h00);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4)      b = key_codes[$urandom_range(0, 7)];
      else if (sel == 5) b = 8'hF0;
      else if (sel == 6) b = 8'hE0;
      else if (sel == 7) b = (n % 3 == 0) ? 8'hAA : ((n % 3 == 1) ? 8'hFA : 8'hFE);
      else               b = 8'($urandom_range(0, 255));
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) != 0);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
      drain("d_rand", 40);
    end

    // Reset mid-frame with W held
    send_frame(8'hF0, 0, 1); send_frame(8'hE0, 0, 1); send_frame(8'h11, 0, 1);
    send_frame(8'h1D, 0, 1); drain("d_pre_rst", 40);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    @(posedge clk); #1 reset = 1'b1;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    md_kd = '0; md_scan = '0; md_brk = 0; md_ext = 0;
    chk("rst_mid_kd", keyboard_data, 8'h00);
    chk("rst_mid_scan", scan_code, 8'h00);
    chk("rst_mid_state", {6'd0, dbg_state}, 8'h00);
    repeat (300) @(posedge clk);
    #1;
    chk("rst_mid_no_err", {7'd0, frame_error}, 8'h00);
    send_frame(8'h1C, 0, 1); drain("d_post_rst", 40);
    chk("kd_a_after_rst", keyboard_data, 8'h02);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
